// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam int ADDR_W   = 10;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 4;
   localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
   localparam int BLOCK_W  = 128;
   localparam int WORD_W   = 32;

   // Field extraction for the default 1 KiB / 8-line geometry.
   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [1:0] addr_word(input logic [ADDR_W-1:0] addr);
      return addr[3:2];
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the cache lines: one synchronous fill port and a
// combinational lookup port returning valid, tag and the selected 32-bit word.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int INDEX_W = 3,
   parameter int TAG_W   = 3
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [BLOCK_W-1:0] wr_block,
   input  logic [INDEX_W-1:0] rd_index,
   input  logic [1:0]         rd_word,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [WORD_W-1:0]  rd_data
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   valid_d;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [BLOCK_W-1:0] data_mem [LINES];
   logic [BLOCK_W-1:0] rd_block;

   // Valid bits: cleared by reset, set by a fill of that line.
   always_comb begin
      valid_d = valid_q;
      if (srst) begin
         valid_d = '0;
      end else if (we) begin
         valid_d[wr_index] = 1'b1;
      end
   end

   // Valid register update.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
   end

   // Tag and data arrays are written only by fills and are not reset;
   // a stale entry is harmless while its valid bit is clear.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_block;
      end
   end

   // Lookup port: word w of the block occupies bits [32w+31:32w].
   always_comb begin
      rd_valid = valid_q[rd_index];
      rd_tag   = tag_mem[rd_index];
      rd_block = data_mem[rd_index];
      rd_data  = rd_block[{rd_word, 5'b00000} +: WORD_W];
   end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: zero-latency hits, and on a miss
// a stalled block fetch from instruction memory followed by a replayed lookup.
module icache_controller
   import icache_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int INDEX_W = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   read,
   input  logic [ADDR_W-1:0]      address,
   output logic [WORD_W-1:0]      instruction,
   output logic                   busywait,
   output logic                   mem_read,
   output logic [ADDR_W-5:0]      mem_address,
   input  logic [BLOCK_W-1:0]     mem_readdata,
   input  logic                   mem_busywait
);

   localparam int LINE_TAG_W = ADDR_W - OFFSET_W - INDEX_W;

   logic [LINE_TAG_W-1:0] cpu_tag;
   logic [INDEX_W-1:0]    cpu_index;
   logic [1:0]            cpu_word;
   logic                  unused_addr_bits;

   logic                  line_valid;
   logic [LINE_TAG_W-1:0] line_tag;
   logic                  hit;
   logic                  fill_we;

   state_t                state_q, state_d;
   logic                  guard_q, guard_d;
   logic [LINE_TAG_W-1:0] fill_tag_q, fill_tag_d;
   logic [INDEX_W-1:0]    fill_index_q, fill_index_d;
   logic                  mem_read_q, mem_read_d;
   logic [ADDR_W-5:0]     mem_address_q, mem_address_d;

   // Split the CPU byte address; the byte-within-word bits are don't-care.
   always_comb begin
      cpu_tag          = address[ADDR_W-1 -: LINE_TAG_W];
      cpu_index        = address[OFFSET_W +: INDEX_W];
      cpu_word         = address[3:2];
      unused_addr_bits = ^address[1:0];
   end

   icache_line_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (LINE_TAG_W)
   ) u_line_store (
      .clk      (clock),
      .srst     (reset),
      .we       (fill_we && !reset),
      .wr_index (fill_index_q),
      .wr_tag   (fill_tag_q),
      .wr_block (mem_readdata),
      .rd_index (cpu_index),
      .rd_word  (cpu_word),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (instruction)
   );

   // Hit detection and CPU stall: only IDLE can answer a fetch.
   always_comb begin
      hit      = line_valid && (line_tag == cpu_tag);
      busywait = (state_q == IDLE) ? (read && !hit) : 1'b1;
   end

   // Next-state logic. The fill address is latched at miss detection so a
   // misbehaving CPU that changes address mid-stall cannot redirect the fill.
   // The first FETCH cycle ignores mem_busywait, giving memory one cycle to
   // see the freshly registered request before its ready is trusted.
   always_comb begin
      state_d       = state_q;
      guard_d       = guard_q;
      fill_tag_d    = fill_tag_q;
      fill_index_d  = fill_index_q;
      mem_read_d    = mem_read_q;
      mem_address_d = mem_address_q;
      fill_we       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (read && !hit) begin
               fill_tag_d    = cpu_tag;
               fill_index_d  = cpu_index;
               mem_read_d    = 1'b1;
               mem_address_d = {cpu_tag, cpu_index};
               guard_d       = 1'b1;
               state_d       = FETCH;
            end
         end
         FETCH: begin
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!mem_busywait) begin
               fill_we    = 1'b1;
               mem_read_d = 1'b0;
               state_d    = UPDATE;
            end
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            mem_read_d = 1'b0;
         end
      endcase
   end

   // FSM and registered memory-interface outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         guard_q       <= 1'b0;
         fill_tag_q    <= '0;
         fill_index_q  <= '0;
         mem_read_q    <= 1'b0;
         mem_address_q <= '0;
      end else begin
         state_q       <= state_d;
         guard_q       <= guard_d;
         fill_tag_q    <= fill_tag_d;
         fill_index_q  <= fill_index_d;
         mem_read_q    <= mem_read_d;
         mem_address_q <= mem_address_d;
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_address = mem_address_q;

endmodule
